div_radix2_unit: RTL and testbench

//  Iterative radix-2 restoring divider for DIV/DIVU. It is the responder on the controller's
//  div_validE/signed_divE request: it sits in the execute stage beside the ALU and raises a

---
 rtl/div_radix2_if.sv | 24 ++
 rtl/div_radix2_unit.sv | 120 ++++++++++++
 tb/tb_div_radix2_unit.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/div_radix2_if.sv
// Request/response bundle between the execute-stage controller and the divider.
// master = pipeline side, slave = divider side.
interface div_radix2_if #(
    parameter int WIDTH = 32
);
    logic                 start_i;
    logic                 signed_i;
    logic                 annul_i;
    logic [WIDTH-1:0]     a_i;
    logic [WIDTH-1:0]     b_i;
    logic                 stall_o;
    logic                 ready_o;
    logic [2*WIDTH-1:0]   result_o;

    modport master (
        output start_i, signed_i, annul_i, a_i, b_i,
        input  stall_o, ready_o, result_o
    );

    modport slave (
        input  start_i, signed_i, annul_i, a_i, b_i,
        output stall_o, ready_o, result_o
    );
endinterface

// File: rtl/div_radix2_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU.
// Returns {remainder, quotient} for the HI/LO write; one quotient bit per cycle.
// Optional feature macro: DIV_EARLY_EXIT_EN -- finish immediately when |a| < |b|.
module div_radix2_unit #(
    parameter int WIDTH = 32
) (
    input  logic         clk,
    input  logic         rst,
    div_radix2_if.slave  bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t               state_q;
    logic [CW-1:0]        cnt_q;
    logic [WIDTH-1:0]     dvd_q;      // dividend magnitude, shifts left; quotient bits enter at LSB
    logic [WIDTH-1:0]     dsr_q;      // divisor magnitude
    logic [WIDTH-1:0]     rem_q;      // partial remainder
    logic                 neg_q_q;    // negate quotient at the end
    logic                 neg_r_q;    // negate remainder at the end
    logic                 ready_q;
    logic [2*WIDTH-1:0]   result_q;

    logic [WIDTH-1:0]     abs_a;
    logic [WIDTH-1:0]     abs_b;
    logic                 early;
    logic [WIDTH:0]       trial;
    logic                 qbit;
    logic [WIDTH-1:0]     rem_nxt;
    logic [WIDTH-1:0]     quo_nxt;
    logic [WIDTH-1:0]     q_fix;
    logic [WIDTH-1:0]     r_fix;

    // Operand magnitudes, one restoring step, and final sign correction.
    always_comb begin
        abs_a = (bus.signed_i && bus.a_i[WIDTH-1]) ? -bus.a_i : bus.a_i;
        abs_b = (bus.signed_i && bus.b_i[WIDTH-1]) ? -bus.b_i : bus.b_i;
`ifdef DIV_EARLY_EXIT_EN
        early = (abs_a < abs_b);
`else
        early = 1'b0;
`endif
        // Bit WIDTH of the trial difference is set exactly when it went negative.
        trial   = {rem_q, dvd_q[WIDTH-1]} - {1'b0, dsr_q};
        qbit    = ~trial[WIDTH];
        rem_nxt = qbit ? trial[WIDTH-1:0] : {rem_q[WIDTH-2:0], dvd_q[WIDTH-1]};
        quo_nxt = {dvd_q[WIDTH-2:0], qbit};
        q_fix   = neg_q_q ? -quo_nxt : quo_nxt;
        r_fix   = neg_r_q ? -rem_nxt : rem_nxt;
    end

    // Control FSM and datapath registers; ready/result are registered on entry to DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            dvd_q    <= '0;
            dsr_q    <= '0;
            rem_q    <= '0;
            neg_q_q  <= 1'b0;
            neg_r_q  <= 1'b0;
            ready_q  <= 1'b0;
            result_q <= '0;
        end else begin
            ready_q <= 1'b0;
            if (bus.annul_i) begin
                // Flush wins over everything, including a same-cycle start.
                state_q <= IDLE;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (bus.start_i) begin
                            if (bus.b_i == '0) begin
                                // Divide by zero: quotient all ones, remainder is raw a.
                                result_q <= {bus.a_i, {WIDTH{1'b1}}};
                                ready_q  <= 1'b1;
                                state_q  <= DONE;
                            end else if (early) begin
                                // |a| < |b|: q=0 and r=a with the dividend's sign intact.
                                result_q <= {bus.a_i, {WIDTH{1'b0}}};
                                ready_q  <= 1'b1;
                                state_q  <= DONE;
                            end else begin
                                dvd_q   <= abs_a;
                                dsr_q   <= abs_b;
                                rem_q   <= '0;
                                cnt_q   <= '0;
                                neg_q_q <= bus.signed_i & (bus.a_i[WIDTH-1] ^ bus.b_i[WIDTH-1]);
                                neg_r_q <= bus.signed_i & bus.a_i[WIDTH-1];
                                state_q <= CALC;
                            end
                        end
                    end
                    CALC: begin
                        rem_q <= rem_nxt;
                        dvd_q <= quo_nxt;
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == CW'(WIDTH - 1)) begin
                            result_q <= {r_fix, q_fix};
                            ready_q  <= 1'b1;
                            state_q  <= DONE;
                        end
                    end
                    DONE: begin
                        state_q <= IDLE;
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.stall_o  = bus.start_i & ~ready_q & ~bus.annul_i & ~rst;
    assign bus.ready_o  = ready_q;
    assign bus.result_o = result_q;

endmodule

// File: tb/tb_div_radix2_unit.sv
// Self-checking bench for div_radix2_unit: directed corner cases, random
// operands against a magnitude-based reference, flush, back-to-back and async reset.
module tb_div_radix2_unit;
    logic clk = 1'b0;
    logic rst;
    int   vecs = 0;
    int   errs = 0;
    logic [63:0] last_res;

    div_radix2_if #(.WIDTH(32)) bus ();

    div_radix2_unit #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // Reference: divide magnitudes, then apply the sign rules.
    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic na, nb;
        longint unsigned ma, mb, q, r;
        logic [31:0] qq, rr;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        na = s & a[31];
        nb = s & b[31];
        ma = na ? (64'h1_0000_0000 - {32'd0, a}) : {32'd0, a};
        mb = nb ? (64'h1_0000_0000 - {32'd0, b}) : {32'd0, b};
        q  = ma / mb;
        r  = ma % mb;
        qq = q[31:0];
        rr = r[31:0];
        if (na ^ nb) qq = -qq;
        if (na)      rr = -rr;
        return {rr, qq};
    endfunction

    function automatic int ref_lat(input logic [31:0] a, input logic [31:0] b, input logic s);
        longint unsigned ma, mb;
        ma = (s & a[31]) ? (64'h1_0000_0000 - {32'd0, a}) : {32'd0, a};
        mb = (s & b[31]) ? (64'h1_0000_0000 - {32'd0, b}) : {32'd0, b};
        if (b == 32'd0) return 1;
`ifdef DIV_EARLY_EXIT_EN
        if (ma < mb) return 1;
`endif
        return 33;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one division starting this cycle and follow it to ready_o.
    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic s, input string nm);
        logic [63:0] exp;
        int lat, n;
        bit seen;
        exp  = ref_div(a, b, s);
        lat  = ref_lat(a, b, s);
        bus.start_i  = 1'b1;
        bus.signed_i = s;
        bus.a_i      = a;
        bus.b_i      = b;
        bus.annul_i  = 1'b0;
        n    = 0;
        seen = 1'b0;
        while (!seen && n <= 40) begin
            @(negedge clk);
            if (bus.ready_o === 1'b1) begin
                seen = 1'b1;
                vecs++;
                if (n !== lat) begin
                    errs++;
                    $display("FAIL %s latency: got %0d expected %0d", nm, n, lat);
                end
                vecs++;
                if (bus.result_o !== exp) begin
                    errs++;
                    $display("FAIL %s result: got %h expected %h (a=%h b=%h s=%0d)", nm, bus.result_o, exp, a, b, s);
                end
                vecs++;
                if (bus.stall_o !== 1'b0) begin
                    errs++;
                    $display("FAIL %s stall at ready: got %b expected 0", nm, bus.stall_o);
                end
            end else begin
                vecs++;
                if (bus.stall_o !== 1'b1 || bus.result_o !== last_res) begin
                    errs++;
                    $display("FAIL %s busy cycle %0d: stall=%b result=%h expected stall=1 result=%h", nm, n, bus.stall_o, bus.result_o, last_res);
                end
            end
            step();
            n++;
        end
        if (!seen) begin
            vecs++;
            errs++;
            $display("FAIL %s timeout: no ready_o within 40 cycles, expected %0d", nm, lat);
        end
        last_res = exp;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start_i = 1'b0; bus.signed_i = 1'b0; bus.annul_i = 1'b0;
        bus.a_i = '0; bus.b_i = '0;
        #12;
        vecs++;
        if (bus.ready_o !== 1'b0 || bus.stall_o !== 1'b0 || bus.result_o !== 64'd0) begin
            errs++;
            $display("FAIL reset: ready=%b stall=%b result=%h expected 0/0/0", bus.ready_o, bus.stall_o, bus.result_o);
        end
        step();
        rst = 1'b0;
        last_res = 64'd0;
        step();
    endtask

    task automatic test_directed();
        run_div(32'd100, 32'd7, 1'b0, "divu_100_7");
        bus.start_i = 1'b0; step();
        run_div(32'hFFFF_FFF9, 32'd2, 1'b1, "div_m7_2");
        bus.start_i = 1'b0; step();
        run_div(32'd7, 32'hFFFF_FFFE, 1'b1, "div_7_m2");
        bus.start_i = 1'b0; step();
        run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, "div_min_m1");
        bus.start_i = 1'b0; step();
        run_div(32'hFFFF_FFFF, 32'd1, 1'b0, "divu_max_1");
        bus.start_i = 1'b0; step();
        run_div(32'h1234, 32'd0, 1'b0, "div_by_zero");
        bus.start_i = 1'b0; step();
        run_div(32'hFFFF_FFF0, 32'd0, 1'b1, "sdiv_by_zero");
        bus.start_i = 1'b0; step();
        run_div(32'd3, 32'd9, 1'b0, "divu_3_9");
        bus.start_i = 1'b0; step();
        run_div(32'hFFFF_FFFD, 32'd9, 1'b1, "div_m3_9");
        bus.start_i = 1'b0; step();
    endtask

    task automatic test_random();
        logic [31:0] a, b;
        logic s;
        for (int i = 0; i < 24; i++) begin
            a = $urandom();
            b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom();
            if ($urandom_range(0, 4) == 0) a = 32'($urandom_range(0, 100));
            s = 1'($urandom_range(0, 1));
            run_div(a, b, s, "random");
            bus.start_i = 1'b0;
            if ($urandom_range(0, 1) == 1) step();
        end
    endtask

    // Flush mid-calculation at T+10; a fresh start at T+12 must take full latency.
    task automatic test_annul();
        bus.start_i = 1'b1; bus.signed_i = 1'b0; bus.annul_i = 1'b0;
        bus.a_i = 32'd100; bus.b_i = 32'd7;
        for (int c = 0; c < 10; c++) step();
        bus.annul_i = 1'b1;
        @(negedge clk);
        vecs++;
        if (bus.stall_o !== 1'b0 || bus.ready_o !== 1'b0) begin
            errs++;
            $display("FAIL annul cycle: stall=%b ready=%b expected 0/0", bus.stall_o, bus.ready_o);
        end
        step();
        bus.annul_i = 1'b0;
        bus.start_i = 1'b0;
        @(negedge clk);
        vecs++;
        if (bus.ready_o !== 1'b0 || bus.result_o !== last_res) begin
            errs++;
            $display("FAIL annul after: ready=%b result=%h expected 0 and %h", bus.ready_o, bus.result_o, last_res);
        end
        step();
        run_div(32'd1000, 32'd33, 1'b0, "after_annul");
        bus.start_i = 1'b0; step();
    endtask

    // start_i stays high across instructions; each must be accepted the cycle after ready.
    task automatic test_back_to_back();
        run_div(32'd500, 32'd6, 1'b0, "b2b_0");
        run_div(32'hFFFF_FC18, 32'd0, 1'b1, "b2b_1");
        run_div(32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b1, "b2b_2");
        bus.start_i = 1'b0; step();
    endtask

    task automatic test_async_reset();
        bus.start_i = 1'b1; bus.signed_i = 1'b0; bus.annul_i = 1'b0;
        bus.a_i = 32'd3; bus.b_i = 32'd9;
        for (int c = 0; c < 5; c++) step();
        #2 rst = 1'b1;
        #1;
        vecs++;
        if (bus.stall_o !== 1'b0 || bus.ready_o !== 1'b0 || bus.result_o !== 64'd0) begin
            errs++;
            $display("FAIL async_reset: stall=%b ready=%b result=%h expected 0/0/0", bus.stall_o, bus.ready_o, bus.result_o);
        end
        bus.start_i = 1'b0;
        step();
        rst = 1'b0;
        last_res = 64'd0;
        step();
        run_div(32'd77, 32'd5, 1'b0, "after_rst");
        bus.start_i = 1'b0; step();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_annul();
        test_back_to_back();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end
endmodule
